// File: rtl/spring_controller_pkg.sv
// Shared state type and default tuning constants
// for the plunger spring controller.
package spring_controller_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHARGING  = 2'd1,
        RELEASING = 2'd2,
        COOLDOWN  = 2'd3
    } state_t;

    localparam logic [10:0] DEF_SPRING_REST_Y   = 11'd400;
    localparam logic [5:0]  DEF_MAX_COMPRESSION = 6'd40;
    localparam logic [5:0]  DEF_RELEASE_STEP    = 6'd8;
    localparam logic [3:0]  DEF_SPEED_GAIN      = 4'd8;
    localparam logic [4:0]  DEF_COOLDOWN_FRAMES = 5'd30;

endpackage

// File: rtl/frame_step_counter.sv
// Frame-enabled counter: load, +1 saturating at MAX,
// or -STEP floored at zero.
module frame_step_counter #(
    parameter int         W    = 6,
    parameter logic [W-1:0] MAX  = '1,
    parameter logic [W-1:0] STEP = 1
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         up,
    input  logic         down,
    output logic [W-1:0] count,
    output logic [W-1:0] nextCount
);

    // Next value; only a frame pulse moves the count
    always_comb begin
        nextCount = count;
        if (en) begin
            if (load)
                nextCount = loadVal;
            else if (up)
                nextCount = (count >= MAX) ? MAX : count + 1'b1;
            else if (down)
                nextCount = (count > STEP) ? count - STEP : '0;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            count <= '0;
        else
            count <= nextCount;
    end

endmodule

// File: rtl/spring_controller.sv
// Plunger spring: charge while the key is held, decay on
// release, fire the ball if it sits on the spring.
module spring_controller
    import spring_controller_pkg::*;
#(
    parameter logic [10:0] SPRING_REST_Y   = DEF_SPRING_REST_Y,
    parameter logic [5:0]  MAX_COMPRESSION = DEF_MAX_COMPRESSION,
    parameter logic [5:0]  RELEASE_STEP    = DEF_RELEASE_STEP,
    parameter logic [3:0]  SPEED_GAIN      = DEF_SPEED_GAIN,
    parameter logic [4:0]  COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        pullKey,
    input  logic        ballOnSpring,
    output logic [10:0] springTopY,
    output logic [5:0]  compression,
    output logic        launch,
    output logic [10:0] launchSpeedY,
    output logic        busy
);

    state_t      state;
    logic [5:0]  peak;
    logic [4:0]  cdCount;
    logic [5:0]  nextComp;
    logic [10:0] launchMag;
    logic        load;
    logic        up;
    logic        down;

    assign load = (state == IDLE) && pullKey;
    assign up   = (state == CHARGING) && pullKey;
    assign down = (state == RELEASING);

    frame_step_counter #(
        .W    (6),
        .MAX  (MAX_COMPRESSION),
        .STEP (RELEASE_STEP)
    ) u_comp (
        .clk       (clk),
        .resetN    (resetN),
        .en        (startOfFrame),
        .load      (load),
        .loadVal   (6'd1),
        .up        (up),
        .down      (down),
        .count     (compression),
        .nextCount (nextComp)
    );

    assign launchMag = 11'(peak) * 11'(SPEED_GAIN);
    assign busy      = (state != IDLE);

    // Frame-stepped FSM, launch pulse and spring position
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            peak         <= '0;
            cdCount      <= '0;
            launch       <= 1'b0;
            launchSpeedY <= '0;
            springTopY   <= SPRING_REST_Y;
        end else begin
            launch     <= 1'b0;
            springTopY <= SPRING_REST_Y + 11'(nextComp);
            if (startOfFrame) begin
                unique case (state)
                    IDLE: begin
                        if (pullKey)
                            state <= CHARGING;
                    end
                    CHARGING: begin
                        if (!pullKey) begin
                            state <= RELEASING;
                            peak  <= compression;
                        end
                    end
                    RELEASING: begin
                        if (nextComp == '0) begin
                            state   <= COOLDOWN;
                            cdCount <= '0;
                            if (ballOnSpring) begin
                                launch       <= 1'b1;
                                launchSpeedY <= -launchMag;
                            end
                        end
                    end
                    COOLDOWN: begin
                        if (cdCount == COOLDOWN_FRAMES - 5'd1)
                            state <= IDLE;
                        else
                            cdCount <= cdCount + 5'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spring_controller.sv
// Bench for spring_controller: reference model checked
// every cycle plus directed literal expectations.
module tb_spring_controller;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        pullKey;
    logic        ballOnSpring;
    logic [10:0] springTopY;
    logic [5:0]  compression;
    logic        launch;
    logic [10:0] launchSpeedY;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int nLaunch = 0;
    bit started = 0;

    always #5 clk = ~clk;

    spring_controller dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .pullKey      (pullKey),
        .ballOnSpring (ballOnSpring),
        .springTopY   (springTopY),
        .compression  (compression),
        .launch       (launch),
        .launchSpeedY (launchSpeedY),
        .busy         (busy)
    );

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Reference model: phases, frames left in cooldown
    localparam int P_IDLE = 0;
    localparam int P_CHG  = 1;
    localparam int P_REL  = 2;
    localparam int P_COOL = 3;

    int          m_phase;
    int          m_comp;
    int          m_peak;
    int          m_left;
    logic        m_launch;
    logic [10:0] m_speed;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_phase  = P_IDLE;
            m_comp   = 0;
            m_peak   = 0;
            m_left   = 0;
            m_launch = 0;
            m_speed  = '0;
        end else begin
            m_launch = 0;
            if (startOfFrame) begin
                if (m_phase == P_IDLE) begin
                    if (pullKey) begin
                        m_phase = P_CHG;
                        m_comp  = 1;
                    end
                end else if (m_phase == P_CHG) begin
                    if (pullKey) begin
                        m_comp = (m_comp + 1 > 40) ? 40 : m_comp + 1;
                    end else begin
                        m_phase = P_REL;
                        m_peak  = m_comp;
                    end
                end else if (m_phase == P_REL) begin
                    m_comp = (m_comp > 8) ? m_comp - 8 : 0;
                    if (m_comp == 0) begin
                        if (ballOnSpring) begin
                            m_launch = 1;
                            m_speed  = 11'(0 - m_peak * 8);
                        end
                        m_phase = P_COOL;
                        m_left  = 30;
                    end
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0)
                        m_phase = P_IDLE;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (launch === 1'b1)
            nLaunch++;
        if (started) begin
            check("springTopY", 32'(springTopY), 32'(400 + m_comp));
            check("compression", 32'(compression), 32'(m_comp));
            check("launch", 32'(launch), 32'(m_launch));
            check("launchSpeedY", 32'(launchSpeedY), 32'(m_speed));
            check("busy", 32'(busy), 32'(m_phase != P_IDLE));
        end
    end

    task automatic frame(input logic pk, input logic bos);
        pullKey      = pk;
        ballOnSpring = bos;
        startOfFrame = 1'b1;
        @(posedge clk); #2;
        startOfFrame = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
    endtask

    task automatic frames(input int n, input logic pk,
                          input logic bos);
        repeat (n) frame(pk, bos);
    endtask

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        pullKey      = 1'b0;
        ballOnSpring = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_top", 32'(springTopY), 32'd400);
        check("rst_comp", 32'(compression), 32'd0);
        check("rst_launch", 32'(launch), 32'd0);
        check("rst_speed", 32'(launchSpeedY), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        resetN  = 1'b1;
        started = 1;

        // 10-frame charge, launch at -80
        nLaunch = 0;
        frames(10, 1, 1);
        frame(0, 1);
        check("c10_comp", 32'(compression), 32'd10);
        check("c10_top", 32'(springTopY), 32'd410);
        frame(0, 1);
        check("c10_decay", 32'(compression), 32'd2);
        frame(0, 1);
        check("c10_zero", 32'(compression), 32'd0);
        check("c10_launches", 32'(nLaunch), 32'd1);
        check("c10_speed", 32'(launchSpeedY), 32'h7B0);
        frames(29, 0, 0);
        check("cool29_busy", 32'(busy), 32'd1);
        frame(0, 0);
        check("cool30_busy", 32'(busy), 32'd0);

        // saturation at 40, launch at -320
        nLaunch = 0;
        frames(60, 1, 1);
        check("sat_comp", 32'(compression), 32'd40);
        check("sat_top", 32'(springTopY), 32'd440);
        frame(0, 1);
        frames(5, 0, 1);
        check("sat_zero", 32'(compression), 32'd0);
        check("sat_launches", 32'(nLaunch), 32'd1);
        check("sat_speed", 32'(launchSpeedY), 32'h6C0);
        frames(30, 0, 0);

        // no ball: no launch, speed held
        nLaunch = 0;
        frames(5, 1, 0);
        frame(0, 0);
        frame(0, 0);
        check("nob_comp", 32'(compression), 32'd0);
        check("nob_launches", 32'(nLaunch), 32'd0);
        check("nob_busy", 32'(busy), 32'd1);
        check("nob_speed", 32'(launchSpeedY), 32'h6C0);
        frames(30, 0, 0);

        // key held through release and cooldown
        frames(3, 1, 1);
        frame(0, 1);
        check("hold_rel", 32'(compression), 32'd3);
        frame(1, 1);
        check("hold_zero", 32'(compression), 32'd0);
        frames(29, 1, 1);
        check("hold_comp", 32'(compression), 32'd0);
        check("hold_busy29", 32'(busy), 32'd1);
        frame(1, 1);
        check("hold_idle", 32'(busy), 32'd0);
        frame(1, 1);
        check("hold_rearm", 32'(busy), 32'd1);
        check("hold_c1", 32'(compression), 32'd1);
        frame(0, 0);
        frame(0, 0);
        frames(30, 0, 0);

        // tap: compression 1, launch at -8
        nLaunch = 0;
        frame(1, 1);
        check("tap_comp", 32'(compression), 32'd1);
        frame(0, 1);
        check("tap_rel", 32'(compression), 32'd1);
        frame(0, 1);
        check("tap_zero", 32'(compression), 32'd0);
        check("tap_launches", 32'(nLaunch), 32'd1);
        check("tap_speed", 32'(launchSpeedY), 32'h7F8);
        frames(30, 0, 0);

        // reset one frame before launch
        nLaunch = 0;
        frames(10, 1, 1);
        frame(0, 1);
        frame(0, 1);
        check("pre_rst_comp", 32'(compression), 32'd2);
        resetN = 1'b0;
        #1;
        check("ar_top", 32'(springTopY), 32'd400);
        check("ar_comp", 32'(compression), 32'd0);
        check("ar_launch", 32'(launch), 32'd0);
        check("ar_speed", 32'(launchSpeedY), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        resetN = 1'b1;
        frame(0, 1);
        check("ar_after_launches", 32'(nLaunch), 32'd0);
        check("ar_after_busy", 32'(busy), 32'd0);
        frame(1, 1);
        check("ar_rearm", 32'(compression), 32'd1);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule

// File: doc/spring_controller.md
SPRING_CONTROLLER -- requirements
Module: spring_controller

Interface
REQ-001 SHALL have parameters: SPRING_REST_Y=11'd400 (spring top Y at rest); MAX_COMPRESSION=6'd40 (pixels); RELEASE_STEP=6'd8 (pixels per frame on release); SPEED_GAIN=4'd8 (speed units per pixel); COOLDOWN_FRAMES=5'd30.
REQ-002 SHALL have ports, one clock, reset asynchronous active-low:
  clk  in  1  system clock
  resetN  in  1  asynchronous active-low reset
  startOfFrame  in  1  one-cycle pulse per video frame
  pullKey  in  1  plunger key level, 1 = held
  ballOnSpring  in  1  level, 1 = ball resting on spring top
  springTopY  out  11  current spring top Y, drives spring rectangle offset
  compression  out  6  current compression, pixels
  launch  out  1  one-cycle launch pulse
  launchSpeedY  out  11  two's-complement Y speed, valid with launch
  busy  out  1  1 whenever state != IDLE

Function
REQ-003 SHALL implement states IDLE, CHARGING, RELEASING, COOLDOWN; all state and counter changes occur only on clk edges where startOfFrame=1, except the launch clear (REQ-009).
REQ-004 IDLE: startOfFrame & pullKey -> CHARGING, compression <= 1 on the same edge.
REQ-005 CHARGING: startOfFrame & pullKey -> compression +1, saturating at MAX_COMPRESSION; startOfFrame & !pullKey -> RELEASING, peak <= compression, compression unchanged on that edge.
REQ-006 RELEASING: each startOfFrame -> compression <= compression - RELEASE_STEP, floored at 0 (no wrap); pullKey ignored.
REQ-007 RELEASING edge where compression reaches 0: if ballOnSpring=1 on that edge, launch <= 1 and launchSpeedY <= -(peak * SPEED_GAIN); either way -> COOLDOWN, cooldown counter <= 0.
REQ-008 COOLDOWN: each startOfFrame increments counter; on the edge where counter = COOLDOWN_FRAMES-1 -> IDLE; pullKey ignored throughout, including when held into IDLE (IDLE re-arms on the next frame with pullKey=1).
REQ-009 launch SHALL be high for exactly one clk cycle; cleared on the next edge regardless of startOfFrame; launchSpeedY holds its value until the next launch.
REQ-010 springTopY SHALL equal SPRING_REST_Y + compression (zero-extended), registered, updated on the same edge as compression.
REQ-011 Arithmetic: peak*SPEED_GAIN max 320, fits 11-bit signed; negation is two's complement on 11 bits.
REQ-012 All outputs SHALL be registered; latency from startOfFrame sample to output change is one edge.
REQ-013 busy SHALL be combinational from state (state != IDLE).

Reset
REQ-014 resetN=0 SHALL immediately force: state IDLE, compression 0, peak 0, cooldown counter 0, springTopY SPRING_REST_Y, launch 0, launchSpeedY 0, busy 0.
REQ-015 Reset mid-RELEASING SHALL suppress any pending launch; after release, behaviour resumes per REQ-004.

Structure
REQ-016 State enum and the five constants' default values SHALL reside in the shared defines package.
REQ-017 One sub-module, frame_step_counter (saturating up/down counter with frame enable), SHALL be used for compression; cooldown counter is inline.

Verification
REQ-018 Hold pullKey 10 frames, release -> compression 10, springTopY 410 at release; decays 10,2,0; with ballOnSpring=1 launch pulse of 1 cycle, launchSpeedY = -80 (11'h7B0).
REQ-019 Hold pullKey 60 frames -> compression saturates at 40, springTopY 440; release with ballOnSpring=1 -> launchSpeedY = -320 (11'h6C0).
REQ-020 Release with ballOnSpring=0 -> compression reaches 0, no launch pulse, state COOLDOWN, busy 1.
REQ-021 pullKey held continuously through RELEASING and COOLDOWN -> no compression increase; IDLE after exactly 30 COOLDOWN frames, CHARGING on next frame.
REQ-022 Assert resetN=0 one frame before compression reaches 0 in RELEASING -> launch never pulses; all outputs at reset values immediately.
REQ-023 pullKey pulse 1 frame (tap) -> compression 1, release -> 0 after one frame, launchSpeedY -8 when ballOnSpring=1.
